plot_scheduler: RTL and testbench

Sequences all screen updates for the DX-Ball game onto the single-pixel VGA adapter write port. Three requesters (ball, paddle, block logic) each post a rectangle update: old position, new position, size and colour. The scheduler grants one requester at a time in round-robin order. For the granted update it erases the old rectangle to background, draws the new rectangle, then acknowledges. It sits between the game-logic blocks and the `vga_adapter` plot inputs.

---
 rtl/plot_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_plot_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/plot_scheduler.sv
// rtl/plot_scheduler.sv - round-robin rectangle erase/draw sequencer onto a single-pixel plot port
module plot_scheduler #(
   parameter int         MAX_X     = 159,
   parameter int         MAX_Y     = 119,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [2:0]  req,
   input  logic [23:0] req_new_x,
   input  logic [20:0] req_new_y,
   input  logic [23:0] req_old_x,
   input  logic [20:0] req_old_y,
   input  logic [23:0] req_size_x,
   input  logic [20:0] req_size_y,
   input  logic [8:0]  req_colour,
   output logic [2:0]  ack,
   output logic        busy,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_plot
);

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

   state_t      state, state_n;
   logic [1:0]  rr_ptr, rr_n, g, g_n;
   logic [7:0]  old_x, old_x_n, new_x, new_x_n, sx, sx_n, cx, cx_n;
   logic [6:0]  old_y, old_y_n, new_y, new_y_n, sy, sy_n, cy, cy_n;
   logic [2:0]  col, col_n;
   logic [2:0]  ack_n;
   logic        busy_n;
   logic [7:0]  vx_n;
   logic [6:0]  vy_n;
   logic [2:0]  vc_n;
   logic        vp_n;

   logic [1:0]  sel;
   logic [7:0]  f_old_x, f_new_x, f_sx;
   logic [6:0]  f_old_y, f_new_y, f_sy;
   logic [2:0]  f_col;

   // First set request at or after rr_ptr; scanning offsets high to low lets the smallest offset win.
   always_comb begin
      sel = rr_ptr;
      for (int k = 2; k >= 0; k--) begin
         int j;
         j = int'(rr_ptr) + k;
         if (j >= 3) j = j - 3;
         if (req[j]) sel = 2'(j);
      end
      f_old_x = req_old_x[int'(sel)*8 +: 8];
      f_new_x = req_new_x[int'(sel)*8 +: 8];
      f_sx    = req_size_x[int'(sel)*8 +: 8];
      f_old_y = req_old_y[int'(sel)*7 +: 7];
      f_new_y = req_new_y[int'(sel)*7 +: 7];
      f_sy    = req_size_y[int'(sel)*7 +: 7];
      f_col   = req_colour[int'(sel)*3 +: 3];
   end

   logic        em, last, row_end;
   logic [7:0]  bx, ex;
   logic [6:0]  by, ey;
   logic [2:0]  ec;
   logic [8:0]  px;
   logic [7:0]  py;

   always_comb begin
      state_n = state;
      rr_n    = rr_ptr;
      g_n     = g;
      old_x_n = old_x;
      old_y_n = old_y;
      new_x_n = new_x;
      new_y_n = new_y;
      sx_n    = sx;
      sy_n    = sy;
      col_n   = col;
      cx_n    = cx;
      cy_n    = cy;
      ack_n   = 3'b000;
      em      = 1'b0;
      bx      = 8'd0;
      by      = 7'd0;
      ex      = 8'd0;
      ey      = 7'd0;
      ec      = 3'b000;
      row_end = (cx == sx - 8'd1);
      last    = row_end && (cy == sy - 7'd1);

      case (state)
         IDLE: begin
            if (|req) begin
               g_n     = sel;
               old_x_n = f_old_x;
               old_y_n = f_old_y;
               new_x_n = f_new_x;
               new_y_n = f_new_y;
               sx_n    = f_sx;
               sy_n    = f_sy;
               col_n   = f_col;
               cx_n    = 8'd0;
               cy_n    = 7'd0;
               if (f_sx == 8'd0 || f_sy == 7'd0) begin
                  state_n = DONE;
                  ack_n   = 3'b001 << sel;
               end else begin
                  state_n = ERASE;
                  em      = 1'b1;
                  bx      = f_old_x;
                  by      = f_old_y;
                  ec      = BG_COLOUR;
               end
            end
         end
         ERASE, DRAW: begin
            if (last) begin
               cx_n = 8'd0;
               cy_n = 7'd0;
            end else if (row_end) begin
               cx_n = 8'd0;
               cy_n = cy + 7'd1;
            end else begin
               cx_n = cx + 8'd1;
            end
            // The registered vga_* outputs carry the pixel for the count being entered.
            if (state == ERASE && last) begin
               state_n = DRAW;
               em      = 1'b1;
               bx      = new_x;
               by      = new_y;
               ec      = col;
            end else if (state == DRAW && last) begin
               state_n = DONE;
               ack_n   = 3'b001 << g;
            end else begin
               em = 1'b1;
               bx = (state == ERASE) ? old_x : new_x;
               by = (state == ERASE) ? old_y : new_y;
               ec = (state == ERASE) ? BG_COLOUR : col;
               ex = cx_n;
               ey = cy_n;
            end
         end
         DONE: begin
            rr_n    = (g == 2'd2) ? 2'd0 : g + 2'd1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      px     = {1'b0, bx} + {1'b0, ex};
      py     = {1'b0, by} + {1'b0, ey};
      vp_n   = em && (px <= 9'(MAX_X)) && (py <= 8'(MAX_Y));
      vx_n   = em ? px[7:0] : 8'd0;
      vy_n   = em ? py[6:0] : 7'd0;
      vc_n   = em ? ec : 3'b000;
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         rr_ptr     <= 2'd0;
         g          <= 2'd0;
         old_x      <= 8'd0;
         old_y      <= 7'd0;
         new_x      <= 8'd0;
         new_y      <= 7'd0;
         sx         <= 8'd0;
         sy         <= 7'd0;
         col        <= 3'b000;
         cx         <= 8'd0;
         cy         <= 7'd0;
         ack        <= 3'b000;
         busy       <= 1'b0;
         vga_x      <= 8'd0;
         vga_y      <= 7'd0;
         vga_colour <= 3'b000;
         vga_plot   <= 1'b0;
      end else begin
         state      <= state_n;
         rr_ptr     <= rr_n;
         g          <= g_n;
         old_x      <= old_x_n;
         old_y      <= old_y_n;
         new_x      <= new_x_n;
         new_y      <= new_y_n;
         sx         <= sx_n;
         sy         <= sy_n;
         col        <= col_n;
         cx         <= cx_n;
         cy         <= cy_n;
         ack        <= ack_n;
         busy       <= busy_n;
         vga_x      <= vx_n;
         vga_y      <= vy_n;
         vga_colour <= vc_n;
         vga_plot   <= vp_n;
      end
   end

endmodule

// File: tb/tb_plot_scheduler.sv
// tb/tb_plot_scheduler.sv - self-checking bench for plot_scheduler
module tb_plot_scheduler;

   logic        clk = 1'b0;
   logic        resetn;
   logic [2:0]  req;
   logic [23:0] req_new_x, req_old_x, req_size_x;
   logic [20:0] req_new_y, req_old_y, req_size_y;
   logic [8:0]  req_colour;
   logic [2:0]  ack;
   logic        busy;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;

   plot_scheduler dut (
      .clk(clk), .resetn(resetn), .req(req),
      .req_new_x(req_new_x), .req_new_y(req_new_y),
      .req_old_x(req_old_x), .req_old_y(req_old_y),
      .req_size_x(req_size_x), .req_size_y(req_size_y),
      .req_colour(req_colour), .ack(ack), .busy(busy),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   always #10 clk = ~clk;

   typedef struct {int idx; int ox; int oy; int nx; int ny; int sx; int sy; int col;} rect_t;
   typedef struct {int x; int y; int c;} pix_t;
   typedef struct {rect_t r; int exp_plots; int exp_lat;} vec_t;

   int   n_err = 0;
   int   n_chk = 0;
   int   plot_cnt = 0;
   pix_t exp_q[$];
   rect_t cur[3];
   vec_t vecs[8];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Scoreboard consumer: every plotted pixel must match the next expected visible pixel.
   always @(negedge clk) begin
      if (vga_plot) begin
         pix_t p;
         plot_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_plot", 1, 0);
         end else begin
            p = exp_q.pop_front();
            chk("pix_x", int'(vga_x), p.x);
            chk("pix_y", int'(vga_y), p.y);
            chk("pix_colour", int'(vga_colour), p.c);
         end
      end
   end

   function automatic void push_pixels(input rect_t r);
      for (int pass = 0; pass < 2; pass++) begin
         int bx, by;
         bx = pass ? r.nx : r.ox;
         by = pass ? r.ny : r.oy;
         for (int y = 0; y < r.sy; y++)
            for (int x = 0; x < r.sx; x++)
               if (bx + x <= 159 && by + y <= 119)
                  exp_q.push_back('{bx + x, by + y, pass ? r.col : 0});
      end
   endfunction

   task automatic set_fields(input rect_t r);
      req_old_x[r.idx*8 +: 8]  = 8'(r.ox);
      req_old_y[r.idx*7 +: 7]  = 7'(r.oy);
      req_new_x[r.idx*8 +: 8]  = 8'(r.nx);
      req_new_y[r.idx*7 +: 7]  = 7'(r.ny);
      req_size_x[r.idx*8 +: 8] = 8'(r.sx);
      req_size_y[r.idx*7 +: 7] = 7'(r.sy);
      req_colour[r.idx*3 +: 3] = 3'(r.col);
      cur[r.idx] = r;
   endtask

   task automatic wait_ack(input int idx, input int lat, input string nm);
      int cnt;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (ack == 3'b000 && cnt < lat + 5);
      chk({nm, "_ack"}, int'(ack), 1 << idx);
      chk({nm, "_latency"}, cnt, lat);
      req[idx] = 1'b0;
   endtask

   task automatic check_idle(input string nm, input int plots);
      @(negedge clk);
      chk({nm, "_busy_after_ack"}, int'(busy), 0);
      chk({nm, "_plot_count"}, plot_cnt, plots);
      chk({nm, "_queue_left"}, exp_q.size(), 0);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      set_fields(v.r);
      push_pixels(v.r);
      plot_cnt = 0;
      req[v.r.idx] = 1'b1;
      wait_ack(v.r.idx, v.exp_lat, nm);
      check_idle(nm, v.exp_plots);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // idx, old x,y, new x,y, size x,y, colour ; expected plots, ack latency
      vecs[0] = '{'{0, 50, 4, 51, 5, 4, 4, 7}, 32, 33};
      vecs[1] = '{'{1, 70, 110, 74, 110, 8, 2, 3}, 32, 33};
      vecs[2] = '{'{2, 100, 100, 158, 118, 4, 4, 5}, 20, 33};
      vecs[3] = '{'{2, 10, 10, 20, 20, 0, 3, 4}, 0, 1};
      vecs[4] = '{'{0, 159, 119, 159, 119, 1, 1, 6}, 2, 3};
      vecs[5] = '{'{1, 5, 5, 6, 6, 5, 0, 2}, 0, 1};
      vecs[6] = '{'{0, 160, 0, 0, 120, 2, 1, 1}, 0, 5};
      vecs[7] = '{'{2, 250, 10, 152, 5, 10, 1, 1}, 8, 21};

      resetn = 1'b0;
      req = 3'b000;
      req_new_x = '0; req_new_y = '0; req_old_x = '0; req_old_y = '0;
      req_size_x = '0; req_size_y = '0; req_colour = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({ack, busy, vga_plot, vga_x, vga_y, vga_colour}), 0);

      // All three requesting at reset release: grant order 0,1,2, twice.
      set_fields('{0, 10, 10, 12, 12, 2, 2, 1});
      set_fields('{1, 40, 100, 44, 100, 3, 1, 2});
      set_fields('{2, 80, 30, 80, 32, 1, 2, 4});
      for (int round = 0; round < 2; round++) begin
         for (int k = 0; k < 3; k++) push_pixels(cur[k]);
         plot_cnt = 0;
         req = 3'b111;
         resetn = 1'b1;
         wait_ack(0, 9, "simul_g0");
         wait_ack(1, 8, "simul_g1");
         wait_ack(2, 6, "simul_g2");
         check_idle("simul", 18);
      end

      // Paddle alone leaves the pointer at 2; ball then wins over paddle.
      run_vec('{'{1, 30, 100, 31, 100, 2, 1, 3}, 4, 5}, "mid_paddle");
      set_fields('{0, 60, 60, 61, 61, 1, 2, 5});
      set_fields('{1, 30, 100, 32, 100, 2, 1, 3});
      push_pixels(cur[0]);
      push_pixels(cur[1]);
      plot_cnt = 0;
      req = 3'b011;
      wait_ack(0, 5, "mid_g_ball");
      wait_ack(1, 6, "mid_g_paddle");
      check_idle("mid", 8);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset during DRAW pixel 5: abandon, then full re-grant of the held request.
      set_fields('{0, 20, 20, 30, 30, 4, 4, 2});
      push_pixels(cur[0]);
      plot_cnt = 0;
      req = 3'b001;
      repeat (22) @(negedge clk);
      chk("mid_reset_pixel_x", int'(vga_x), 31);
      chk("mid_reset_pixel_y", int'(vga_y), 31);
      resetn = 1'b0;
      @(negedge clk);
      chk("mid_reset_outputs", int'({ack, busy, vga_plot, vga_x, vga_y, vga_colour}), 0);
      exp_q.delete();
      push_pixels(cur[0]);
      plot_cnt = 0;
      resetn = 1'b1;
      wait_ack(0, 33, "regrant");
      check_idle("regrant", 32);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
